alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- EX-stage execution unit; consumes the 3-bit ALU control code from the ALU control decoder plus two 32-bit operands.
- Single-cycle ops (AND/XOR/SLL/ADD/SUB/SRAI) produce a registered result one cycle after accept.
- MUL runs on an iterative radix-4 shift-add engine. busy_o stalls the pipeline via the hazard unit until the product is ready.

Parameters:
- XLEN, 32, operand/result width.
- MUL_STEP, 2, multiplier bits consumed per RUN cycle; ITER = XLEN/MUL_STEP = 16.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operation present in EX.
- flush_i  input  1  discard the current or in-flight operation.
- ALUCtrl_i  input  3  op code: AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, SRAI=110, 111 reserved.
- data1_i  input  XLEN  rs1 operand / multiplicand.
- data2_i  input  XLEN  rs2 or immediate / multiplier; shift amount is data2_i[4:0].
- result_o  output  XLEN  registered result.
- valid_o  output  1  result_o valid this cycle; one-cycle pulse per op.
- busy_o  output  1  combinational stall request to the hazard unit.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; result_o=0; valid_o=0; count=0; accumulators cleared. busy_o=0 while in reset.
- Reset mid-MUL aborts the op; no valid_o follows.
- States:
  - IDLE: accepts when valid_i=1 and flush_i=0.
  - RUN: iterates the multiplier.
  - DONE: presents the product.
- IDLE, non-MUL accept:
  - Next edge: result_o = op(data1_i, data2_i); valid_o=1.
  - Stays in IDLE, so back-to-back ops issue every cycle.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLL is logical; SRAI is arithmetic (sign-filled). Both shift by data2_i[4:0].
  - Reserved code 111 gives result_o=0 with valid_o=1.
- IDLE, MUL accept:
  - busy_o=1 combinationally in the accept cycle.
  - Next edge: latch operands, clear accumulator, count=0, go to RUN.
- RUN:
  - busy_o=1; valid_i ignored (upstream holds).
  - Each cycle: acc += multiplicand * mplr[MUL_STEP-1:0]; multiplicand <<= MUL_STEP; mplr >>= MUL_STEP; count++.
  - After ITER cycles: result_o = acc[XLEN-1:0], valid_o=1, go to DONE.
  - The low-XLEN product is identical for signed and unsigned operands.
- DONE:
  - Lasts one cycle; busy_o=0 and valid_i ignored, so the held MUL leaves EX without re-accept.
  - Returns to IDLE at the next edge.
- Latency:
  - Non-MUL: 1 cycle.
  - MUL: busy_o high for 1+ITER = 17 cycles; valid_o in the following (DONE) cycle.
- valid_o is high for exactly one cycle per completed op; otherwise 0. result_o holds its last value.
- flush_i:
  - Any state goes to IDLE next edge; no valid_o; busy_o deasserts the cycle after flush.
  - flush_i together with valid_i in IDLE: flush wins, nothing accepted.
  - flush_i in DONE: valid_o from that cycle already issued; forced to IDLE.
- rst_i overrides flush_i.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- Defined: in RUN, if the remaining shifted multiplier is 0 after a step, go directly to DONE with the result. MUL latency becomes 1 + ceil(msb_index(data2_i)+1 / MUL_STEP) RUN cycles, minimum 1. data2_i=0 still takes 1 RUN cycle.
- Undefined: always exactly ITER RUN cycles.

Decomposition:
- Shared package alu_pkg:
  - ALU control codes (AND..SRAI, reserved).
  - ALUOp encodings (R-type 00, immediate 01).
  - State enum {IDLE, RUN, DONE}.
  - XLEN default.
- One sub-module, alu_mul_iter: owns the accumulator, operand shift registers, count and early-term logic.
  - Interface: start, operands, done pulse, product.
  - alu_exec_unit keeps the FSM, single-cycle datapath and output register.

Test Plan:
- ADD 5+7, then SUB 3−5 back-to-back → result_o=0x0000000C, then 0xFFFFFFFE on consecutive cycles; valid_o high both cycles; busy_o never high.
- SRAI 0x80000000 by 4; SLL 0x00000001 by 31; XOR 0xF0F0F0F0^0xFFFFFFFF → 0xF8000000, 0x80000000, 0x0F0F0F0F.
- MUL 0xFFFFFFFF×3 with valid_i held through busy → busy_o high 17 cycles, then one valid_o with 0xFFFFFFFD; no second accept in DONE. ALU_MUL_EARLY_TERM_EN build: busy_o high 2 cycles.
- MUL 6×7, flush_i at RUN cycle 5 → busy_o low next cycle, no valid_o. A following ADD 1+1 returns 2 with 1-cycle latency.
- MUL 0x12345678×0x9ABCDEF0, rst_i at RUN cycle 8 → outputs 0 immediately. After release, a fresh MUL gives 0x242D2080.
- ALUCtrl_i=111 with valid_i → result_o=0, valid_o=1; flush_i and valid_i together in IDLE → no valid_o.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage execution unit: ALU control codes,
// ALUOp encodings, the execution FSM state type and default widths.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int MUL_STEP_DEF = 2;

    // 3-bit code produced by the ALU control decoder
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SRAI = 3'b110,
        ALU_RSVD = 3'b111
    } alu_ctrl_e;

    // ALUOp encodings fed to the ALU control decoder
    typedef enum logic [1:0] {
        ALUOP_RTYPE = 2'b00,
        ALUOP_IMM   = 2'b01
    } alu_op_e;

    // Execution FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// ----------------------------------------------------------------------------
// alu_exec_unit_if
// Operation/result bundle between the EX pipeline stage and alu_exec_unit.
//   valid_i, flush_i, ALUCtrl_i, data1_i, data2_i : request side (pipeline)
//   result_o, valid_o, busy_o                      : response side (unit)
// master = pipeline side, slave = execution unit.
// ----------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            flush_i;
    logic [2:0]      ALUCtrl_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic [XLEN-1:0] result_o;
    logic            valid_o;
    logic            busy_o;

    modport master (
        output valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
        input  result_o, valid_o, busy_o
    );

    modport slave (
        input  valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
        output result_o, valid_o, busy_o
    );
endinterface

// File: rtl/alu_mul_iter.sv
// ----------------------------------------------------------------------------
// alu_mul_iter
// Iterative radix-2^MUL_STEP shift-add multiplier producing the low XLEN bits
// of the product (identical for signed and unsigned operands).
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : load operands, clear accumulator and count
//   run_i         : perform one step this cycle
//   mcand_i       : multiplicand
//   mplr_i        : multiplier
//   done_o        : high in the cycle that performs the final step
//   product_o     : accumulator value after this cycle's step
// Optional: define ALU_MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero.
// ----------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MUL_STEP = MUL_STEP_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            run_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0] mplr_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int ITER  = XLEN / MUL_STEP;
    localparam int CNT_W = $clog2(ITER) + 1;

    logic [XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]  mplr_r;
    logic [XLEN-1:0]  acc_r;
    logic [CNT_W-1:0] count_r;

    logic [XLEN-1:0]  partial_s;
    logic [XLEN-1:0]  acc_nxt_s;
    logic [XLEN-1:0]  mplr_nxt_s;
    logic             last_step_s;

    // Partial product of the multiplicand with the low MUL_STEP multiplier bits
    always_comb begin
        partial_s = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            partial_s = partial_s + (mplr_r[k] ? (mcand_r << k) : {XLEN{1'b0}});
        end
    end

    assign acc_nxt_s  = acc_r + partial_s;
    assign mplr_nxt_s = mplr_r >> MUL_STEP;

`ifdef ALU_MUL_EARLY_TERM_EN
    // Nothing left to add once the shifted-out multiplier is zero
    assign last_step_s = (mplr_nxt_s == {XLEN{1'b0}}) ||
                         (count_r == CNT_W'(ITER - 1));
`else
    assign last_step_s = (count_r == CNT_W'(ITER - 1));
`endif

    assign done_o    = run_i & last_step_s;
    assign product_o = acc_nxt_s;

    // Operand shift registers, accumulator and step counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_r <= '0;
            mplr_r  <= '0;
            acc_r   <= '0;
            count_r <= '0;
        end else if (start_i) begin
            mcand_r <= mcand_i;
            mplr_r  <= mplr_i;
            acc_r   <= '0;
            count_r <= '0;
        end else if (run_i) begin
            mcand_r <= mcand_r << MUL_STEP;
            mplr_r  <= mplr_nxt_s;
            acc_r   <= acc_nxt_s;
            count_r <= count_r + CNT_W'(1);
        end else begin
            mcand_r <= mcand_r;
            mplr_r  <= mplr_r;
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// EX-stage execution unit. Single-cycle ops (AND/XOR/SLL/ADD/SUB/SRAI) give a
// registered result one cycle after accept; MUL runs on alu_mul_iter and
// holds busy_o high until the product is ready.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_exec_unit_if.slave (valid_i, flush_i, ALUCtrl_i, data1_i,
//           data2_i in; result_o, valid_o registered out; busy_o
//           combinational stall request out)
// Optional: ALU_MUL_EARLY_TERM_EN enables early MUL termination.
// ----------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MUL_STEP = MUL_STEP_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_exec_unit_if.slave bus
);

    alu_state_e      state_r;
    alu_state_e      state_nxt_s;
    alu_ctrl_e       ctrl_s;
    logic            accept_s;
    logic            mul_start_s;
    logic            single_s;
    logic            mul_run_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_product_s;
    logic [XLEN-1:0] single_res_s;
    logic [XLEN-1:0] result_r;
    logic            valid_r;

    // Single-cycle datapath; MUL and the reserved code evaluate to zero
    function automatic logic [XLEN-1:0] alu_single(input alu_ctrl_e c,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (c)
            ALU_AND:  return a & b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << shamt;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SRAI: return $unsigned($signed(a) >>> shamt);
            default:  return {XLEN{1'b0}};
        endcase
    endfunction

    assign ctrl_s       = alu_ctrl_e'(bus.ALUCtrl_i);
    // flush_i beats valid_i: nothing is accepted in a flushed cycle
    assign accept_s     = (state_r == ST_IDLE) & bus.valid_i & ~bus.flush_i;
    assign mul_start_s  = accept_s & (ctrl_s == ALU_MUL);
    assign single_s     = accept_s & (ctrl_s != ALU_MUL);
    assign mul_run_s    = (state_r == ST_RUN) & ~bus.flush_i;
    assign single_res_s = alu_single(ctrl_s, bus.data1_i, bus.data2_i);

    alu_mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_s),
        .run_i     (mul_run_s),
        .mcand_i   (bus.data1_i),
        .mplr_i    (bus.data2_i),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (mul_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result register and one-cycle valid pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_r <= '0;
            valid_r  <= 1'b0;
        end else if (single_s) begin
            result_r <= single_res_s;
            valid_r  <= 1'b1;
        end else if (mul_done_s) begin
            result_r <= mul_product_s;
            valid_r  <= 1'b1;
        end else begin
            result_r <= result_r;
            valid_r  <= 1'b0;
        end
    end

    // Stall covers the MUL accept cycle and every RUN cycle; never during reset
    assign bus.busy_o   = ~rst_i & (mul_start_s | (state_r == ST_RUN));
    assign bus.result_o = result_r;
    assign bus.valid_o  = valid_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit with hand-computed results.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

`ifdef ALU_MUL_EARLY_TERM_EN
    localparam int BUSY_SMALL = 2;
`else
    localparam int BUSY_SMALL = 17;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = v;
        bus.flush_i   = f;
        bus.ALUCtrl_i = c;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    // Hold a MUL until its result appears, then drop valid_i; observe 40 cycles
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int busy_n, output int vld_n);
        busy_n = 0;
        vld_n  = 0;
        res    = '0;
        drive(1'b1, 1'b0, 3'b101, a, b);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.busy_o) busy_n++;
            if (bus.valid_o) begin
                vld_n++;
                res = bus.result_o;
            end
            tick();
            if (vld_n != 0) bus.valid_i = 1'b0;
        end
    endtask

    logic [31:0] mres;
    int          mbusy;
    int          mvld;
    int          vcount;

    initial begin
        // reset with a MUL request pending: busy_o must stay low
        drive(1'b1, 1'b0, 3'b101, 32'd6, 32'd7);
        #3;
        check_eq("rst_result", bus.result_o, 32'h0);
        check_eq("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick();

        // ADD then SUB back-to-back
        drive(1'b1, 1'b0, 3'b011, 32'd5, 32'd7);
        #1 check_eq("add_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        check_eq("add_res", bus.result_o, 32'h0000000C);
        check_eq("add_vld", {31'd0, bus.valid_o}, 32'd1);
        drive(1'b1, 1'b0, 3'b100, 32'd3, 32'd5);
        #1 check_eq("sub_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        check_eq("sub_res", bus.result_o, 32'hFFFFFFFE);
        check_eq("sub_vld", {31'd0, bus.valid_o}, 32'd1);

        // SRAI, SLL, XOR, AND, ADD wrap
        drive(1'b1, 1'b0, 3'b110, 32'h80000000, 32'd4);
        tick();
        check_eq("srai", bus.result_o, 32'hF8000000);
        drive(1'b1, 1'b0, 3'b010, 32'h00000001, 32'd31);
        tick();
        check_eq("sll", bus.result_o, 32'h80000000);
        drive(1'b1, 1'b0, 3'b001, 32'hF0F0F0F0, 32'hFFFFFFFF);
        tick();
        check_eq("xor", bus.result_o, 32'h0F0F0F0F);
        drive(1'b1, 1'b0, 3'b000, 32'hFF00FF00, 32'h0F0F0F0F);
        tick();
        check_eq("and", bus.result_o, 32'h0F000F00);
        drive(1'b1, 1'b0, 3'b011, 32'hFFFFFFFF, 32'h00000001);
        tick();
        check_eq("add_wrap", bus.result_o, 32'h00000000);
        check_eq("add_wrap_vld", {31'd0, bus.valid_o}, 32'd1);
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        check_eq("idle_vld", {31'd0, bus.valid_o}, 32'd0);

        // MUL held through busy
        run_mul(32'hFFFFFFFF, 32'd3, mres, mbusy, mvld);
        check_eq("mul_res", mres, 32'hFFFFFFFD);
        check_eq("mul_busy_cycles", mbusy, BUSY_SMALL);
        check_eq("mul_vld_count", mvld, 32'd1);

        // MUL flushed at RUN cycle 5
        drive(1'b1, 1'b0, 3'b101, 32'd6, 32'd7);
        repeat (5) tick();
        drive(1'b0, 1'b1, 3'b101, 32'd6, 32'd7);
        #1 check_eq("flush_busy_same", {31'd0, bus.busy_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1 check_eq("flush_busy_next", {31'd0, bus.busy_o}, 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o) vcount++;
            tick();
        end
        check_eq("flush_no_vld", vcount, 32'd0);
        drive(1'b1, 1'b0, 3'b011, 32'd1, 32'd1);
        tick();
        check_eq("post_flush_add", bus.result_o, 32'd2);
        check_eq("post_flush_vld", {31'd0, bus.valid_o}, 32'd1);

        // reset at RUN cycle 8
        drive(1'b1, 1'b0, 3'b101, 32'h12345678, 32'h9ABCDEF0);
        repeat (8) tick();
        rst_i = 1'b1;
        #1;
        check_eq("midrst_res", bus.result_o, 32'h0);
        check_eq("midrst_vld", {31'd0, bus.valid_o}, 32'd0);
        check_eq("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o) vcount++;
            tick();
        end
        check_eq("midrst_no_vld", vcount, 32'd0);
        run_mul(32'h12345678, 32'h9ABCDEF0, mres, mbusy, mvld);
        check_eq("mul2_res", mres, 32'h242D2080);
        check_eq("mul2_busy_cycles", mbusy, 32'd17);
        check_eq("mul2_vld_count", mvld, 32'd1);

        // reserved code
        drive(1'b1, 1'b0, 3'b111, 32'h12345678, 32'h1);
        tick();
        check_eq("rsvd_res", bus.result_o, 32'h0);
        check_eq("rsvd_vld", {31'd0, bus.valid_o}, 32'd1);

        // flush together with valid in IDLE
        drive(1'b1, 1'b1, 3'b011, 32'd1, 32'd1);
        #1 check_eq("flush_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        check_eq("flush_idle_vld", {31'd0, bus.valid_o}, 32'd0);
        check_eq("flush_idle_res", bus.result_o, 32'h0);
        drive(1'b1, 1'b1, 3'b101, 32'd1, 32'd1);
        #1 check_eq("flush_idle_mul_busy", {31'd0, bus.busy_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1 check_eq("flush_idle_mul_after", {31'd0, bus.busy_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
